multicycle_ctrl_fsm: RTL and testbench



---
 rtl/multicycle_ctrl_fsm_if.sv | 37 +++
 rtl/multicycle_ctrl_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/status bundle between the multi-cycle MIPS sequencer and its datapath + unified memory.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl_fsm_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             iord;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_control;
    logic [1:0]       pc_src;
    logic             pc_en;
    logic [CNT_W-1:0] retire_cnt;
    logic             illegal;
    logic [3:0]       state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_control, pc_src, pc_en, retire_cnt, illegal, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_control, pc_src, pc_en, retire_cnt, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Sequencer for the multi-cycle MIPS datapath: decode, datapath selects, memory handshake,
// retire counting and trap. Define MULTICYCLE_CTRL_JUMP_EN to add the j (opcode 000010) path.
module multicycle_ctrl_fsm #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input logic                   clk,
    input logic                   rst_n,
    multicycle_ctrl_fsm_if.master bus
);
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StImmEx  = 4'd9,
        StImmWb  = 4'd10,
        StJump   = 4'd11,
        StTrap   = 4'd12
    } state_e;

    state_e           state_q;
    state_e           decode_next;
    logic [5:0]       opcode_q;
    logic [5:0]       funct_q;
    logic [CNT_W-1:0] retire_q;
    logic [TMO_W-1:0] tmo_q;
    logic             waiting;
    logic             tmo_hit;
    logic             retire;

    always_comb begin
        decode_next = StTrap;
        case (bus.opcode)
            OpRtype: begin
                if (bus.funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt}) decode_next = StExec;
            end
            OpLw, OpSw:     decode_next = StMemAdr;
            OpBeq:          decode_next = StBranch;
            OpAddi, OpAndi: decode_next = StImmEx;
`ifdef MULTICYCLE_CTRL_JUMP_EN
            OpJ:            decode_next = StJump;
`endif
            default:        decode_next = StTrap;
        endcase
    end

    // mem_ready on the cycle the count would reach TIMEOUT still completes the access.
    always_comb begin
        waiting = state_q inside {StFetch, StMemRd, StMemWr};
        tmo_hit = (TIMEOUT != 0) && waiting && !bus.mem_ready &&
                  ((32'(tmo_q) + 32'd1) >= TIMEOUT);
        retire  = (state_q inside {StMemWb, StAluWb, StBranch, StImmWb, StJump}) ||
                  ((state_q == StMemWr) && bus.mem_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StFetch;
            opcode_q <= '0;
            funct_q  <= '0;
            retire_q <= '0;
            tmo_q    <= '0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (bus.mem_ready)  state_q <= StDecode;
                    else if (tmo_hit)   state_q <= StTrap;
                end
                StDecode: begin
                    opcode_q <= bus.opcode;
                    funct_q  <= bus.funct;
                    state_q  <= decode_next;
                end
                StMemAdr: state_q <= (opcode_q == OpSw) ? StMemWr : StMemRd;
                StMemRd: begin
                    if (bus.mem_ready)  state_q <= StMemWb;
                    else if (tmo_hit)   state_q <= StTrap;
                end
                StMemWr: begin
                    if (bus.mem_ready)  state_q <= StFetch;
                    else if (tmo_hit)   state_q <= StTrap;
                end
                StExec:  state_q <= StAluWb;
                StImmEx: state_q <= StImmWb;
                StMemWb, StAluWb, StBranch, StImmWb, StJump: state_q <= StFetch;
                default: state_q <= StTrap;
            endcase

            if (retire) retire_q <= retire_q + CNT_W'(1);

            // Any cycle that is not a stalled access clears the count, so every wait starts at 0.
            if ((TIMEOUT != 0) && waiting && !bus.mem_ready && !tmo_hit) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end else begin
                tmo_q <= '0;
            end
        end
    end

    always_comb begin
        bus.mem_req     = 1'b0;
        bus.iord        = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_write   = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.alu_control = 3'b000;
        bus.pc_src      = 2'b00;
        bus.pc_en       = 1'b0;
        bus.illegal     = 1'b0;
        bus.state       = rst_n ? state_q : 4'd0;
        bus.retire_cnt  = rst_n ? retire_q : '0;
        if (rst_n) begin
            case (state_q)
                StFetch: begin
                    bus.mem_req     = 1'b1;
                    bus.alu_src_b   = 2'b01;
                    bus.alu_control = 3'b010;
                    bus.ir_write    = bus.mem_ready;
                    bus.pc_en       = bus.mem_ready;
                end
                StDecode: begin
                    bus.alu_src_b   = 2'b11;
                    bus.alu_control = 3'b010;
                end
                StMemAdr: begin
                    bus.alu_src_a   = 1'b1;
                    bus.alu_src_b   = 2'b10;
                    bus.alu_control = 3'b010;
                end
                StMemRd: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                end
                StMemWb: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                StMemWr: begin
                    bus.mem_req   = 1'b1;
                    bus.iord      = 1'b1;
                    bus.mem_write = 1'b1;
                end
                StExec: begin
                    bus.alu_src_a = 1'b1;
                    case (funct_q)
                        FnSub:   bus.alu_control = 3'b110;
                        FnAnd:   bus.alu_control = 3'b000;
                        FnOr:    bus.alu_control = 3'b001;
                        FnSlt:   bus.alu_control = 3'b111;
                        default: bus.alu_control = 3'b010;
                    endcase
                end
                StAluWb: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                end
                StBranch: begin
                    bus.alu_src_a   = 1'b1;
                    bus.alu_control = 3'b110;
                    bus.pc_src      = 2'b01;
                    bus.pc_en       = bus.zero;
                end
                StImmEx: begin
                    bus.alu_src_a   = 1'b1;
                    bus.alu_src_b   = 2'b10;
                    bus.alu_control = (opcode_q == OpAndi) ? 3'b000 : 3'b010;
                end
                StImmWb: bus.reg_write = 1'b1;
`ifdef MULTICYCLE_CTRL_JUMP_EN
                StJump: begin
                    bus.pc_src = 2'b10;
                    bus.pc_en  = 1'b1;
                end
`endif
                StTrap:  bus.illegal = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: one DUT with no timeout and 32-bit counter, one with
// TIMEOUT=4 and a 4-bit counter, both fed the same stimulus and compared to a per-instruction model.
module tb_multicycle_ctrl_fsm;
    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpAndi = 6'b001100;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] FnAdd  = 6'b100000;
    localparam logic [5:0] FnSub  = 6'b100010;
    localparam logic [5:0] FnAnd  = 6'b100100;
    localparam logic [5:0] FnOr   = 6'b100101;
    localparam logic [5:0] FnSlt  = 6'b101010;

    localparam int ClsR = 0, ClsLw = 1, ClsSw = 2, ClsBeq = 3, ClsImm = 4, ClsJ = 5, ClsIll = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.CNT_W(32)) bus_a ();
    multicycle_ctrl_fsm_if #(.CNT_W(4))  bus_b ();

    multicycle_ctrl_fsm #(.CNT_W(32), .TIMEOUT(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    multicycle_ctrl_fsm #(.CNT_W(4),  .TIMEOUT(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int unsigned n_checks   = 0;
    int unsigned n_fail     = 0;
    int unsigned exp_retire = 0;
    bit          pre_wait   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [20:0] pack_a();
        return {bus_a.state, bus_a.illegal, bus_a.mem_req, bus_a.iord, bus_a.mem_write,
                bus_a.ir_write, bus_a.reg_dst, bus_a.mem_to_reg, bus_a.reg_write, bus_a.alu_src_a,
                bus_a.alu_src_b, bus_a.alu_control, bus_a.pc_src, bus_a.pc_en};
    endfunction

    function automatic logic [20:0] pack_b();
        return {bus_b.state, bus_b.illegal, bus_b.mem_req, bus_b.iord, bus_b.mem_write,
                bus_b.ir_write, bus_b.reg_dst, bus_b.mem_to_reg, bus_b.reg_write, bus_b.alu_src_a,
                bus_b.alu_src_b, bus_b.alu_control, bus_b.pc_src, bus_b.pc_en};
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OpR:            return (fn inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt}) ? ClsR : ClsIll;
            OpLw:           return ClsLw;
            OpSw:           return ClsSw;
            OpBeq:          return ClsBeq;
            OpAddi, OpAndi: return ClsImm;
`ifdef MULTICYCLE_CTRL_JUMP_EN
            OpJ:            return ClsJ;
`endif
            default:        return ClsIll;
        endcase
    endfunction

    // Expected outputs of a given state, straight from the per-state output table.
    function automatic logic [20:0] exp_out(input int st, input logic rdy, input logic zr,
                                            input logic [5:0] op, input logic [5:0] fn);
        logic ill, mr, io, mw, irw, rd, m2r, rw, a, pe;
        logic [1:0] b, ps;
        logic [2:0] c;
        {ill, mr, io, mw, irw, rd, m2r, rw, a, pe} = '0;
        b = 2'b00; ps = 2'b00; c = 3'b000;
        case (st)
            0: begin mr = 1; b = 2'b01; c = 3'b010; irw = rdy; pe = rdy; end
            1: begin b = 2'b11; c = 3'b010; end
            2: begin a = 1; b = 2'b10; c = 3'b010; end
            3: begin mr = 1; io = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mr = 1; io = 1; mw = 1; end
            6: begin
                a = 1;
                case (fn)
                    FnSub:   c = 3'b110;
                    FnAnd:   c = 3'b000;
                    FnOr:    c = 3'b001;
                    FnSlt:   c = 3'b111;
                    default: c = 3'b010;
                endcase
            end
            7:  begin rw = 1; rd = 1; end
            8:  begin a = 1; c = 3'b110; ps = 2'b01; pe = zr; end
            9:  begin a = 1; b = 2'b10; c = (op == OpAndi) ? 3'b000 : 3'b010; end
            10: rw = 1;
            11: begin ps = 2'b10; pe = 1; end
            12: ill = 1;
            default: ;
        endcase
        return {4'(st), ill, mr, io, mw, irw, rd, m2r, rw, a, b, c, ps, pe};
    endfunction

    task automatic drive(input logic rdy, input logic [5:0] op, input logic [5:0] fn,
                         input logic zr);
        bus_a.mem_ready = rdy; bus_a.opcode = op; bus_a.funct = fn; bus_a.zero = zr;
        bus_b.mem_ready = rdy; bus_b.opcode = op; bus_b.funct = fn; bus_b.zero = zr;
    endtask

    // One clock cycle: called at posedge+1, checks at negedge, returns at next posedge+1.
    task automatic stepx(input int st_a, input int st_b, input logic rdy,
                         input logic [5:0] op_d, input logic [5:0] fn_d,
                         input logic [5:0] op_i, input logic [5:0] fn_i);
        logic zr;
        zr = rnd1();
        drive(rdy, op_d, fn_d, zr);
        @(negedge clk);
        check_eq($sformatf("out_a st%0d", st_a), 32'(pack_a()),
                 32'(exp_out(st_a, rdy, zr, op_i, fn_i)));
        check_eq($sformatf("out_b st%0d", st_b), 32'(pack_b()),
                 32'(exp_out(st_b, rdy, zr, op_i, fn_i)));
        @(posedge clk);
        #1;
    endtask

    // Outside DECODE the instruction bits are scrambled: the DUT must rely on its latched copy.
    task automatic step(input int st, input logic rdy, input logic [5:0] op, input logic [5:0] fn);
        stepx(st, st, rdy, rnd6(), rnd6(), op, fn);
    endtask

    task automatic do_reset();
        drive(rnd1(), rnd6(), rnd6(), rnd1());
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_out_a", 32'(pack_a()), 32'd0);
        check_eq("rst_out_b", 32'(pack_b()), 32'd0);
        check_eq("rst_ret_a", bus_a.retire_cnt, 32'd0);
        check_eq("rst_ret_b", 32'(bus_b.retire_cnt), 32'd0);
        @(posedge clk);
        #2;
        drive(1'b0, rnd6(), rnd6(), rnd1());
        rst_n = 1'b1;
        #1;
        check_eq("rel_out_a", 32'(pack_a()), 32'(exp_out(0, 1'b0, 1'b0, OpR, FnAdd)));
        check_eq("rel_out_b", 32'(pack_b()), 32'(exp_out(0, 1'b0, 1'b0, OpR, FnAdd)));
        @(posedge clk);
        #1;
        exp_retire = 0;
        pre_wait   = 1'b1;
    endtask

    // d0/d1: stalled cycles before mem_ready in FETCH and in the data access.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int d0,
                             input int d1);
        int cls;
        cls      = classify(op, fn);
        pre_wait = 1'b0;
        check_eq("ret_a", bus_a.retire_cnt, exp_retire);
        check_eq("ret_b", 32'(bus_b.retire_cnt), exp_retire % 16);
        for (int i = 0; i < d0; i++) step(0, 1'b0, op, fn);
        step(0, 1'b1, op, fn);
        stepx(1, 1, rnd1(), op, fn, op, fn);
        case (cls)
            ClsR:   begin step(6, rnd1(), op, fn); step(7, rnd1(), op, fn); end
            ClsLw: begin
                step(2, rnd1(), op, fn);
                for (int i = 0; i < d1; i++) step(3, 1'b0, op, fn);
                step(3, 1'b1, op, fn);
                step(4, rnd1(), op, fn);
            end
            ClsSw: begin
                step(2, rnd1(), op, fn);
                for (int i = 0; i < d1; i++) step(5, 1'b0, op, fn);
                step(5, 1'b1, op, fn);
            end
            ClsBeq: step(8, rnd1(), op, fn);
            ClsImm: begin step(9, rnd1(), op, fn); step(10, rnd1(), op, fn); end
            ClsJ:   step(11, rnd1(), op, fn);
            default: for (int i = 0; i < 3; i++) step(12, rnd1(), op, fn);
        endcase
        if (cls == ClsIll) do_reset();
        else exp_retire++;
    endtask

    task automatic rand_instr(input bit legal_only, output logic [5:0] op, output logic [5:0] fn);
        logic [5:0] rfn [5];
        int unsigned k;
        rfn = '{FnAdd, FnSub, FnAnd, FnOr, FnSlt};
        k   = legal_only ? $urandom_range(0, 6) : $urandom_range(0, 9);
        op  = rnd6();
        fn  = rnd6();
        case (k)
            0, 6: begin op = OpR; fn = rfn[$urandom_range(0, 4)]; end
            1: op = OpLw;
            2: op = OpSw;
            3: op = OpBeq;
            4: op = OpAddi;
            5: op = OpAndi;
            7: op = OpR;
            9: op = OpJ;
            default: ;
        endcase
    endtask

    task automatic run_random(input int n, input bit legal_only);
        logic [5:0] op, fn;
        for (int i = 0; i < n; i++) begin
            rand_instr(legal_only, op, fn);
            run_instr(op, fn, int'($urandom_range(0, pre_wait ? 2 : 3)),
                      int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        drive(1'b0, 6'd0, 6'd0, 1'b0);
        @(posedge clk);
        #1;
        do_reset();

        // Reset while stalled in MEMRD.
        step(0, 1'b1, OpLw, 6'd0);
        stepx(1, 1, 1'b0, OpLw, 6'd0, OpLw, 6'd0);
        step(2, 1'b0, OpLw, 6'd0);
        step(3, 1'b0, OpLw, 6'd0);
        do_reset();

        run_instr(OpR, FnAdd, 0, 0);
        run_instr(OpLw, 6'd0, 0, 3);
        run_instr(OpSw, 6'd0, 1, 2);
        run_instr(OpBeq, 6'd0, 0, 0);
        run_instr(OpBeq, 6'd0, 0, 0);
        run_instr(OpAddi, 6'd0, 0, 0);
        run_instr(OpAndi, 6'd0, 0, 0);
        run_instr(OpR, FnSub, 0, 0);
        run_instr(OpR, FnAnd, 0, 0);
        run_instr(OpR, FnOr, 0, 0);
        run_instr(OpR, FnSlt, 0, 0);
        run_instr(OpJ, 6'd0, 0, 0);
        run_instr(OpR, 6'b000111, 0, 0);
        run_instr(6'b111111, 6'd0, 0, 0);

        // FETCH stall: release cycle + 3 more reach TIMEOUT on dut_b; dut_a keeps waiting.
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1'b0, OpR, FnAdd);
        for (int i = 0; i < 6; i++) stepx(0, 12, 1'b0, rnd6(), rnd6(), OpR, FnAdd);
        stepx(0, 12, 1'b1, rnd6(), rnd6(), OpR, FnAdd);
        stepx(1, 12, 1'b0, 6'b111111, 6'd0, 6'b111111, 6'd0);
        stepx(12, 12, 1'b0, rnd6(), rnd6(), OpR, FnAdd);
        do_reset();
        // mem_ready on the 4th stalled cycle completes the fetch.
        run_instr(OpR, FnAdd, 2, 0);

        run_random(20, 1'b1);
        run_random(300, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
